// File: rtl/fsm_pkg.sv
// Shared definitions for the serializer feeding the sequence-detector FSM.
// Holds the state encoding and the serial line idle level.
package fsm_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic IDLE_LEVEL_DEFAULT = 1'b0;

endpackage

// File: rtl/ser_shift_reg.sv
// Shift register that can be loaded in parallel, with a registered serial output bit.
// The load drives the first bit immediately, and each shift drives the next bit.
module ser_shift_reg
  import fsm_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic             clear,
  input  logic [WIDTH-1:0] data,
  output logic             bit_out
);

  logic [WIDTH-1:0] sreg;

  // sreg holds only the bits that have not yet been driven onto bit_out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg    <= '0;
      bit_out <= IDLE_LEVEL;
    end else if (clear) begin
      sreg    <= '0;
      bit_out <= IDLE_LEVEL;
    end else if (load) begin
      if (MSB_FIRST) begin
        bit_out <= data[WIDTH-1];
        sreg    <= {data[WIDTH-2:0], 1'b0};
      end else begin
        bit_out <= data[0];
        sreg    <= {1'b0, data[WIDTH-1:1]};
      end
    end else if (shift) begin
      if (MSB_FIRST) begin
        bit_out <= sreg[WIDTH-1];
        sreg    <= {sreg[WIDTH-2:0], 1'b0};
      end else begin
        bit_out <= sreg[0];
        sreg    <= {1'b0, sreg[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/fsm_bit_serializer.sv
// Turns parallel words into the bit stream that drives the FSM's X input.
// Each word's first bit appears one cycle after it is accepted; flush drops the word in flight.
module fsm_bit_serializer
  import fsm_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter int   GAP        = 1,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             word_done
);

  localparam int CW = $clog2(WIDTH);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = (GAP > 0) ? GW'(GAP - 1) : GW'(0);

  state_t        state, state_nxt;
  logic [CW-1:0] bit_cnt, bit_cnt_nxt;
  logic [GW-1:0] gap_cnt, gap_cnt_nxt;
  logic          last_bit, last_gap, accept;
  logic          sr_load, sr_shift, sr_clear;

  assign last_bit = (state == S_SHIFT) && (bit_cnt == BIT_LAST);
  assign last_gap = (GAP > 0) && (state == S_GAP) && (gap_cnt == GAP_LAST);

  // The slot that ends a word doubles as the accept slot, so words run back to back.
  assign in_ready  = !flush && ((state == S_IDLE) || ((GAP == 0) ? last_bit : last_gap));
  assign accept    = in_valid && in_ready;
  assign ser_valid = (state == S_SHIFT);
  assign word_done = last_bit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      gap_cnt <= gap_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = '0;
    gap_cnt_nxt = '0;
    sr_load     = 1'b0;
    sr_shift    = 1'b0;
    sr_clear    = 1'b0;
    if (flush) begin
      state_nxt = S_IDLE;
      sr_clear  = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state_nxt = S_SHIFT;
            sr_load   = 1'b1;
          end else begin
            sr_clear = 1'b1;
          end
        end
        S_SHIFT: begin
          if (!last_bit) begin
            sr_shift    = 1'b1;
            bit_cnt_nxt = bit_cnt + 1'b1;
          end else if (GAP > 0) begin
            state_nxt = S_GAP;
            sr_clear  = 1'b1;
          end else if (accept) begin
            sr_load = 1'b1;
          end else begin
            state_nxt = S_IDLE;
            sr_clear  = 1'b1;
          end
        end
        S_GAP: begin
          if (!last_gap) begin
            gap_cnt_nxt = gap_cnt + 1'b1;
            sr_clear    = 1'b1;
          end else if (accept) begin
            state_nxt = S_SHIFT;
            sr_load   = 1'b1;
          end else begin
            state_nxt = S_IDLE;
            sr_clear  = 1'b1;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          sr_clear  = 1'b1;
        end
      endcase
    end
  end

  ser_shift_reg #(
    .WIDTH      (WIDTH),
    .MSB_FIRST  (MSB_FIRST),
    .IDLE_LEVEL (IDLE_LEVEL)
  ) u_shift (
    .clk     (clk),
    .reset   (reset),
    .load    (sr_load),
    .shift   (sr_shift),
    .clear   (sr_clear),
    .data    (in_data),
    .bit_out (ser_out)
  );

endmodule

// File: tb/tb_fsm_bit_serializer.sv
// Directed bench for fsm_bit_serializer: default, GAP=0 and LSB-first instances on one clock.
// Inputs change 2ns after each rising edge; outputs are sampled on the falling edge.
module tb_fsm_bit_serializer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #20 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // default instance (GAP=1, MSB first)
  logic [7:0] d_data = '0;
  logic d_valid = 1'b0, d_flush = 1'b0;
  logic d_ready, d_ser, d_sv, d_done;
  // GAP=0 instance
  logic [7:0] g_data = '0;
  logic g_valid = 1'b0, g_flush = 1'b0;
  logic g_ready, g_ser, g_sv, g_done;
  // LSB-first instance
  logic [7:0] l_data = '0;
  logic l_valid = 1'b0, l_flush = 1'b0;
  logic l_ready, l_ser, l_sv, l_done;

  fsm_bit_serializer u_def (
    .clk(clk), .reset(reset), .in_data(d_data), .in_valid(d_valid), .in_ready(d_ready),
    .flush(d_flush), .ser_out(d_ser), .ser_valid(d_sv), .word_done(d_done)
  );

  fsm_bit_serializer #(.GAP(0)) u_g0 (
    .clk(clk), .reset(reset), .in_data(g_data), .in_valid(g_valid), .in_ready(g_ready),
    .flush(g_flush), .ser_out(g_ser), .ser_valid(g_sv), .word_done(g_done)
  );

  fsm_bit_serializer #(.MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .in_data(l_data), .in_valid(l_valid), .in_ready(l_ready),
    .flush(l_flush), .ser_out(l_ser), .ser_valid(l_sv), .word_done(l_done)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    #10;
    n_checks++;
    if ({d_ser, d_sv, d_ready, d_done} !== 4'b0010)
      $display("FAIL reset_in_reset got ser/sv/rdy/done=%b want 0010", {d_ser, d_sv, d_ready, d_done});
    else n_pass++;
    #20 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({d_ser, d_sv, d_ready, d_done} !== 4'b0010 || g_ready !== 1'b1 || l_ready !== 1'b1)
        $display("FAIL reset_idle[%0d] got ser/sv/rdy/done=%b g_rdy=%b l_rdy=%b want 0010 1 1",
                 i, {d_ser, d_sv, d_ready, d_done}, g_ready, l_ready);
      else n_pass++;
    end
  endtask

  task automatic test_basic_word();
    logic [7:0] w;
    w = 8'h79;
    tick();
    d_data = w; d_valid = 1'b1;
    @(negedge clk);
    n_checks++;
    if (d_ready !== 1'b1) $display("FAIL basic_accept_ready got %b want 1", d_ready);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      tick();
      d_valid = 1'b0; d_data = 8'h00;
      @(negedge clk);
      n_checks++;
      if (d_ser !== w[7-i] || d_sv !== 1'b1 || d_done !== (i == 7) || d_ready !== 1'b0)
        $display("FAIL basic_bit[%0d] got ser=%b sv=%b done=%b rdy=%b want ser=%b sv=1 done=%b rdy=0",
                 i, d_ser, d_sv, d_done, d_ready, w[7-i], (i == 7));
      else n_pass++;
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (d_ser !== 1'b0 || d_sv !== 1'b0 || d_ready !== 1'b1 || d_done !== 1'b0)
      $display("FAIL basic_gap got ser=%b sv=%b rdy=%b done=%b want 0 0 1 0", d_ser, d_sv, d_ready, d_done);
    else n_pass++;
    tick();
    @(negedge clk);
    n_checks++;
    if (d_sv !== 1'b0 || d_ready !== 1'b1)
      $display("FAIL basic_idle got sv=%b rdy=%b want 0 1", d_sv, d_ready);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] s;
    s = 16'hA53C;
    tick();
    g_data = 8'hA5; g_valid = 1'b1;
    @(negedge clk);
    n_checks++;
    if (g_ready !== 1'b1) $display("FAIL b2b_accept_ready got %b want 1", g_ready);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 0) g_data = 8'h3C;
      if (i == 8) begin g_valid = 1'b0; g_data = 8'h00; end
      @(negedge clk);
      n_checks++;
      if (g_ser !== s[15-i] || g_sv !== 1'b1 || g_ready !== (i == 7 || i == 15) ||
          g_done !== (i == 7 || i == 15))
        $display("FAIL b2b_bit[%0d] got ser=%b sv=%b rdy=%b done=%b want ser=%b sv=1 rdy=%b done=%b",
                 i, g_ser, g_sv, g_ready, g_done, s[15-i], (i == 7 || i == 15), (i == 7 || i == 15));
      else n_pass++;
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (g_ser !== 1'b0 || g_sv !== 1'b0 || g_ready !== 1'b1)
      $display("FAIL b2b_idle got ser=%b sv=%b rdy=%b want 0 0 1", g_ser, g_sv, g_ready);
    else n_pass++;
  endtask

  task automatic test_lsb_first();
    tick();
    l_data = 8'h01; l_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      l_valid = 1'b0; l_data = 8'hFE;
      @(negedge clk);
      n_checks++;
      if (l_ser !== (i == 0) || l_sv !== 1'b1 || l_done !== (i == 7))
        $display("FAIL lsb_bit[%0d] got ser=%b sv=%b done=%b want ser=%b sv=1 done=%b",
                 i, l_ser, l_sv, l_done, (i == 0), (i == 7));
      else n_pass++;
    end
    tick();
    tick();
  endtask

  task automatic test_flush();
    logic [7:0] w;
    w = 8'h0F;
    tick();
    d_data = 8'hFF; d_valid = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      tick();
      d_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (d_ser !== 1'b1 || d_sv !== 1'b1)
        $display("FAIL flush_pre_bit[%0d] got ser=%b sv=%b want 1 1", i, d_ser, d_sv);
      else n_pass++;
    end
    tick();
    d_flush = 1'b1; d_valid = 1'b1; d_data = w;
    @(negedge clk);
    n_checks++;
    if (d_ready !== 1'b0 || d_done !== 1'b0 || d_ser !== 1'b1)
      $display("FAIL flush_cycle got rdy=%b done=%b ser=%b want 0 0 1", d_ready, d_done, d_ser);
    else n_pass++;
    tick();
    d_flush = 1'b0;
    @(negedge clk);
    n_checks++;
    if (d_ser !== 1'b0 || d_sv !== 1'b0 || d_ready !== 1'b1 || d_done !== 1'b0)
      $display("FAIL flush_idle got ser=%b sv=%b rdy=%b done=%b want 0 0 1 0", d_ser, d_sv, d_ready, d_done);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      tick();
      d_valid = 1'b0; d_data = 8'h00;
      @(negedge clk);
      n_checks++;
      if (d_ser !== w[7-i] || d_sv !== 1'b1 || d_done !== (i == 7))
        $display("FAIL flush_next_bit[%0d] got ser=%b sv=%b done=%b want ser=%b sv=1 done=%b",
                 i, d_ser, d_sv, d_done, w[7-i], (i == 7));
      else n_pass++;
    end
    tick();
    tick();
  endtask

  task automatic test_async_reset();
    tick();
    d_data = 8'hFF; d_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      d_valid = 1'b0;
    end
    #3;
    n_checks++;
    if (d_ser !== 1'b1 || d_sv !== 1'b1)
      $display("FAIL areset_before got ser=%b sv=%b want 1 1", d_ser, d_sv);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++;
    if (d_ser !== 1'b0 || d_sv !== 1'b0 || d_done !== 1'b0 || d_ready !== 1'b1)
      $display("FAIL areset_immediate got ser=%b sv=%b done=%b rdy=%b want 0 0 0 1",
               d_ser, d_sv, d_done, d_ready);
    else n_pass++;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (d_ser !== 1'b0 || d_sv !== 1'b0 || d_ready !== 1'b1)
        $display("FAIL areset_after[%0d] got ser=%b sv=%b rdy=%b want 0 0 1", i, d_ser, d_sv, d_ready);
      else n_pass++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic_word();
    test_back_to_back();
    test_lsb_first();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
